hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised in-flight destination tracker for the decode stage; successor to the fixed 3-deep a2/en_reg_wr latch chain and raw a2_hazard tap.
- Holds DEPTH slots of pending register writes between decode and writeback, compares decode-stage sources against them, and drives the stall/bubble that freezes fetch/decode on a RAW hazard.
- Supplies the writeback address/enable from its last slot, aligned with the register-file write.

Parameters:
ADDR_W, 5, register address width
DEPTH, 3, pipeline slots from execute to writeback inclusive (legal 1..7)
SEL_W, 3, forward-select width; must satisfy 2**SEL_W > DEPTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
issue_valid  input  1  decode holds a real instruction
src0_addr  input  ADDR_W  first source register (a0)
src0_use  input  1  instruction reads src0
src1_addr  input  ADDR_W  second source register (a1)
src1_use  input  1  instruction reads src1
dst_addr  input  ADDR_W  destination register (a2)
dst_wr  input  1  instruction writes dst (decoded en_reg_wr)
dst_is_load  input  1  instruction is a memory load
ext_stall  input  1  global pipeline stall; freezes all slots
squash  input  1  kill the instruction in decode
hazard_stall  output  1  hold fetch/decode this cycle
bubble  output  1  inject a NOP into execute this cycle
pend_valid  output  DEPTH  per-slot valid, bit k = slot k
pend_addr  output  DEPTH*ADDR_W  per-slot address, slot k at [k*ADDR_W +: ADDR_W]
wb_en  output  1  slot DEPTH-1 valid
wb_addr  output  ADDR_W  slot DEPTH-1 address

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- On reset, every slot is cleared to {valid=0, addr=0, is_load=0}, so all registered outputs read 0. Combinational outputs then evaluate to 0 unless an input hazard is present.
- Slot 0 holds the instruction currently in execute. Slot k is k stages later. Slot DEPTH-1 is in writeback.
- Entry formed in decode: valid = issue_valid & dst_wr & ~squash & ~hazard_stall & (dst_addr != 0), addr = dst_addr, is_load = dst_is_load.
- Per clock with ext_stall=0: slot[0] <= entry; slot[k] <= slot[k-1]. A non-valid entry shifts in as a bubble.
- Per clock with ext_stall=1: all slots hold. This takes priority over hazard and squash.
- Source match: src_use & (src_addr != 0) & any slot k valid with addr == src_addr. Register x0 never matches.
- Without forwarding, every slot counts, including slot DEPTH-1, because the register file does not bypass.
- hazard_stall = issue_valid & ~squash & (match0 | match1). It is combinational.
- bubble = hazard_stall & ~ext_stall.
- Squash forces hazard_stall=0 and an invalid entry. Slots already in flight are not flushed.
- Latency: a dependent instruction issues in the cycle after the producer's slot leaves DEPTH-1. Back-to-back with DEPTH=3, that is 3 stall cycles.
- Duplicate addresses across slots are legal; any valid match stalls.
- Reset asserted mid-hazard clears the slots, and the stall drops in the next cycle.

Optional Feature:
- Macro SCOREBOARD_FORWARD_EN.
- Defined: adds outputs fwd_sel0 and fwd_sel1 (each SEL_W wide).
  - fwd_sel = k+1 for the youngest matching slot k, or 0 for no match or x0.
  - A match on a slot with is_load=1 and k=0 still stalls (load-use). Every other match forwards and does not stall.
  - fwd_sel is valid only while hazard_stall=0.
- Undefined: no fwd ports, and stall on any match as above.

Decomposition:
- Shared package scoreboard_pkg:
  - slot typedef {valid, addr[ADDR_W], is_load}
  - FWD_NONE=0
  - default ADDR_W/DEPTH constants
  - DEPTH range check function
- Natural sub-module: scoreboard_match. One instance per source. Inputs are the source address/use and the slot vector; outputs are the match flag plus the youngest-slot index and load flag.

Test Plan:
- rst=1 for 2 cycles, then release -> pend_valid=0, wb_en=0, hazard_stall=0.
- Issue dst=5 at cycle 0, next instr src0=5 -> hazard_stall=1 for cycles 1-3 and bubble each cycle. wb_en=1, wb_addr=5 at cycle 3. Issue at cycle 4.
- dst=0 write, then src0=0 -> no stall, pend_valid stays 0.
- Producer dst=7, dependent stalling, ext_stall=1 for 4 cycles -> slots frozen, bubble=0, hazard_stall=1. Resumes countdown after release.
- squash=1 with dst=9, dst_wr=1, then src1=9 -> no stall, slot 0 invalid.
- FORWARD_EN: ALU dst=3 then src0=3 -> no stall, fwd_sel0=1. Load dst=4 then src1=4 -> 1 stall cycle, then fwd_sel1=2.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: shared slot layout, defaults and parameter checks for hazard_scoreboard
package scoreboard_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH_DEF = 3;
  localparam int SEL_W_DEF = 3;
  localparam int FWD_NONE = 0;
  typedef struct packed {
    logic valid;
    logic [ADDR_W_DEF-1:0] addr;
    logic is_load;
  } slot_t;
  function automatic bit depth_ok(input int depth, input int sel_w);
    return depth >= 1 && depth <= 7 && (2 ** sel_w) > depth;
  endfunction
endpackage

// File: rtl/scoreboard_match.sv
// scoreboard_match: compares one decode source against every in-flight slot, reports youngest hit
module scoreboard_match import scoreboard_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [ADDR_W-1:0]       src_addr,
  input  logic                    src_use,
  input  logic [DEPTH-1:0]        slot_valid,
  input  logic [DEPTH*ADDR_W-1:0] slot_addr,
  input  logic [DEPTH-1:0]        slot_load,
  output logic                    hit,
  output logic [SEL_W-1:0]        sel,
  output logic                    sel_load
);
  logic [DEPTH-1:0] m;
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign m[i] = src_use & (src_addr != '0) & slot_valid[i] & (slot_addr[i*ADDR_W +: ADDR_W] == src_addr);
  end
  assign hit = |m;
  // walk oldest to youngest so the youngest hit is the one left standing
  always_comb begin
    sel = SEL_W'(FWD_NONE);
    sel_load = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (m[k]) begin
        sel = SEL_W'(k + 1);
        sel_load = slot_load[k];
      end
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight destination tracker driving RAW stall/bubble and writeback address.
// Define SCOREBOARD_FORWARD_EN to add fwd_sel0/fwd_sel1 and stall only on load-use.
module hazard_scoreboard import scoreboard_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic [ADDR_W-1:0]       src0_addr,
  input  logic                    src0_use,
  input  logic [ADDR_W-1:0]       src1_addr,
  input  logic                    src1_use,
  input  logic [ADDR_W-1:0]       dst_addr,
  input  logic                    dst_wr,
  input  logic                    dst_is_load,
  input  logic                    ext_stall,
  input  logic                    squash,
  output logic                    hazard_stall,
  output logic                    bubble,
  output logic [DEPTH-1:0]        pend_valid,
  output logic [DEPTH*ADDR_W-1:0] pend_addr,
  output logic                    wb_en,
  output logic [ADDR_W-1:0]       wb_addr
`ifdef SCOREBOARD_FORWARD_EN
  ,
  output logic [SEL_W-1:0]        fwd_sel0,
  output logic [SEL_W-1:0]        fwd_sel1
`endif
);
  if (!depth_ok(DEPTH, SEL_W)) begin : g_bad_param
    $error("hazard_scoreboard: DEPTH must be 1..7 and below 2**SEL_W");
  end
  typedef struct packed {
    logic valid;
    logic [ADDR_W-1:0] addr;
    logic is_load;
  } wslot_t;
  wslot_t slots [DEPTH];
  wslot_t entry;
  logic [DEPTH-1:0] slot_load;
  logic hit0, hit1, load0, load1, stall0, stall1;
  logic [SEL_W-1:0] sel0, sel1;
  always_comb begin
    entry.valid = issue_valid & dst_wr & ~squash & ~hazard_stall & (dst_addr != '0);
    entry.addr = dst_addr;
    entry.is_load = dst_is_load;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) slots[k] <= '0;
    end else if (!ext_stall) begin
      slots[0] <= entry;
      for (int k = 1; k < DEPTH; k++) slots[k] <= slots[k-1];
    end
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign pend_valid[i] = slots[i].valid;
    assign pend_addr[i*ADDR_W +: ADDR_W] = slots[i].addr;
    assign slot_load[i] = slots[i].is_load;
  end
  assign wb_en = slots[DEPTH-1].valid;
  assign wb_addr = slots[DEPTH-1].addr;
  scoreboard_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match0 (
    .src_addr(src0_addr), .src_use(src0_use), .slot_valid(pend_valid), .slot_addr(pend_addr),
    .slot_load(slot_load), .hit(hit0), .sel(sel0), .sel_load(load0)
  );
  scoreboard_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match1 (
    .src_addr(src1_addr), .src_use(src1_use), .slot_valid(pend_valid), .slot_addr(pend_addr),
    .slot_load(slot_load), .hit(hit1), .sel(sel1), .sel_load(load1)
  );
`ifdef SCOREBOARD_FORWARD_EN
  // only a load still in execute cannot be bypassed
  assign stall0 = hit0 & load0 & (sel0 == SEL_W'(1));
  assign stall1 = hit1 & load1 & (sel1 == SEL_W'(1));
  assign fwd_sel0 = sel0;
  assign fwd_sel1 = sel1;
`else
  assign stall0 = hit0;
  assign stall1 = hit1;
`endif
  assign hazard_stall = issue_valid & ~squash & (stall0 | stall1);
  assign bubble = hazard_stall & ~ext_stall;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed self-checking bench for hazard_scoreboard (DEPTH=3, ADDR_W=5)
module tb_hazard_scoreboard;
  logic clk = 1'b0, rst = 1'b1;
  logic issue_valid = 0, src0_use = 0, src1_use = 0, dst_wr = 0, dst_is_load = 0, ext_stall = 0, squash = 0;
  logic [4:0] src0_addr = 0, src1_addr = 0, dst_addr = 0;
  logic hazard_stall, bubble, wb_en;
  logic [2:0] pend_valid;
  logic [14:0] pend_addr;
  logic [4:0] wb_addr;
`ifdef SCOREBOARD_FORWARD_EN
  logic [2:0] fwd_sel0, fwd_sel1;
`endif
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .src0_addr(src0_addr), .src0_use(src0_use), .src1_addr(src1_addr), .src1_use(src1_use),
    .dst_addr(dst_addr), .dst_wr(dst_wr), .dst_is_load(dst_is_load),
    .ext_stall(ext_stall), .squash(squash),
    .hazard_stall(hazard_stall), .bubble(bubble), .pend_valid(pend_valid), .pend_addr(pend_addr),
    .wb_en(wb_en), .wb_addr(wb_addr)
`ifdef SCOREBOARD_FORWARD_EN
    , .fwd_sel0(fwd_sel0), .fwd_sel1(fwd_sel1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [4:0] d, input logic dw, input logic dl,
                       input logic [4:0] a0, input logic u0, input logic [4:0] a1, input logic u1);
    issue_valid = iv; dst_addr = d; dst_wr = dw; dst_is_load = dl;
    src0_addr = a0; src0_use = u0; src1_addr = a1; src1_use = u1;
    #1;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) tick();
    rst = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (pend_valid !== 3'b000) begin errors++; $display("FAIL reset_pend_valid got %b want 000", pend_valid); end
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en got %b want 0", wb_en); end
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", hazard_stall); end
    checks++; if (pend_addr !== 15'd0) begin errors++; $display("FAIL reset_pend_addr got %h want 0", pend_addr); end
  endtask

  task automatic test_raw();
    logic [2:0] exp_pv [3] = '{3'b001, 3'b010, 3'b100};
    drive(1, 5, 1, 0, 0, 0, 0, 0);
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL raw_producer_stall got %b want 0", hazard_stall); end
    tick();
    drive(1, 6, 1, 0, 5, 1, 0, 0);
    for (int c = 0; c < 3; c++) begin
      checks++; if (hazard_stall !== 1'b1 || bubble !== 1'b1) begin errors++; $display("FAIL raw_stall_c%0d got stall=%b bubble=%b want 1 1", c + 1, hazard_stall, bubble); end
      checks++; if (pend_valid !== exp_pv[c]) begin errors++; $display("FAIL raw_pend_c%0d got %b want %b", c + 1, pend_valid, exp_pv[c]); end
      tick();
    end
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL raw_release got %b want 0", hazard_stall); end
    tick();
    checks++; if (pend_valid !== 3'b001 || pend_addr[4:0] !== 5'd6) begin errors++; $display("FAIL raw_issue got pv=%b a=%0d want 001 6", pend_valid, pend_addr[4:0]); end
    drain();
  endtask

  task automatic test_wb();
    drive(1, 5, 1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    checks++; if (wb_en !== 1'b1 || wb_addr !== 5'd5) begin errors++; $display("FAIL wb_slot got en=%b a=%0d want 1 5", wb_en, wb_addr); end
    tick();
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL wb_drop got %b want 0", wb_en); end
  endtask

  task automatic test_x0();
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    tick();
    checks++; if (pend_valid !== 3'b000) begin errors++; $display("FAIL x0_pend got %b want 000", pend_valid); end
    drive(1, 0, 0, 0, 0, 1, 0, 1);
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL x0_stall got %b want 0", hazard_stall); end
    drain();
  endtask

  task automatic test_ext_stall();
    drive(1, 7, 1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 7, 1);
    tick();
    ext_stall = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (hazard_stall !== 1'b1 || bubble !== 1'b0 || pend_valid !== 3'b010) begin errors++; $display("FAIL ext_hold_c%0d got stall=%b bubble=%b pv=%b want 1 0 010", c, hazard_stall, bubble, pend_valid); end
      tick();
    end
    ext_stall = 0;
    #1;
    checks++; if (bubble !== 1'b1 || pend_valid !== 3'b010) begin errors++; $display("FAIL ext_resume got bubble=%b pv=%b want 1 010", bubble, pend_valid); end
    tick();
    checks++; if (hazard_stall !== 1'b1 || pend_valid !== 3'b100) begin errors++; $display("FAIL ext_count got stall=%b pv=%b want 1 100", hazard_stall, pend_valid); end
    tick();
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL ext_done got %b want 0", hazard_stall); end
    drain();
  endtask

  task automatic test_squash();
    squash = 1;
    drive(1, 9, 1, 0, 0, 0, 0, 0);
    tick();
    squash = 0;
    drive(1, 0, 0, 0, 0, 0, 9, 1);
    checks++; if (pend_valid[0] !== 1'b0 || hazard_stall !== 1'b0) begin errors++; $display("FAIL squash got pv0=%b stall=%b want 0 0", pend_valid[0], hazard_stall); end
    drive(1, 11, 1, 0, 0, 0, 0, 0);
    tick();
    squash = 1;
    drive(1, 0, 0, 0, 11, 1, 0, 0);
    checks++; if (hazard_stall !== 1'b0 || pend_valid !== 3'b001) begin errors++; $display("FAIL squash_hazard got stall=%b pv=%b want 0 001", hazard_stall, pend_valid); end
    squash = 0;
    drain();
  endtask

  task automatic test_back_to_back();
    drive(1, 8, 1, 0, 0, 0, 0, 0);
    tick();
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL dup_second_issue got %b want 0", hazard_stall); end
    tick();
    drive(1, 0, 0, 0, 8, 1, 0, 0);
    for (int c = 0; c < 3; c++) begin
      checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL dup_stall_c%0d got %b want 1", c, hazard_stall); end
      tick();
    end
    checks++; if (hazard_stall !== 1'b0 || pend_valid !== 3'b000) begin errors++; $display("FAIL dup_clear got stall=%b pv=%b want 0 000", hazard_stall, pend_valid); end
    drain();
  endtask

  task automatic test_reset_mid();
    drive(1, 10, 1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 10, 1, 0, 0);
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b want 1", hazard_stall); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++; if (hazard_stall !== 1'b0 || pend_valid !== 3'b000) begin errors++; $display("FAIL rstmid_post got stall=%b pv=%b want 0 000", hazard_stall, pend_valid); end
    drain();
  endtask

`ifdef SCOREBOARD_FORWARD_EN
  task automatic test_forward();
    drive(1, 3, 1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 3, 1, 0, 0);
    checks++; if (hazard_stall !== 1'b0 || fwd_sel0 !== 3'd1) begin errors++; $display("FAIL fwd_alu got stall=%b sel=%0d want 0 1", hazard_stall, fwd_sel0); end
    drain();
    drive(1, 4, 1, 1, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 4, 1);
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL fwd_load_use got %b want 1", hazard_stall); end
    tick();
    checks++; if (hazard_stall !== 1'b0 || fwd_sel1 !== 3'd2) begin errors++; $display("FAIL fwd_load_after got stall=%b sel=%0d want 0 2", hazard_stall, fwd_sel1); end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_raw();
    test_wb();
    test_x0();
    test_ext_stall();
    test_squash();
    test_back_to_back();
    test_reset_mid();
`ifdef SCOREBOARD_FORWARD_EN
    test_forward();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
